// File: rtl/pcmcia_host_pkg.sv
// Shared types for the PCMCIA/CF host initiator.
// Command codes, FSM states, status bits, strobe decode.
package pcmcia_host_pkg;

  localparam logic [2:0] CMD_ATTR_RD = 3'd0;
  localparam logic [2:0] CMD_ATTR_WR = 3'd1;
  localparam logic [2:0] CMD_MEM_RD  = 3'd2;
  localparam logic [2:0] CMD_MEM_WR  = 3'd3;
  localparam logic [2:0] CMD_IO_RD   = 3'd4;
  localparam logic [2:0] CMD_IO_WR   = 3'd5;

  localparam int STAT_TIMEOUT   = 0;
  localparam int STAT_NO_INPACK = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_STRETCH,
    ST_HOLD,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    STB_NONE,
    STB_OE,
    STB_WE,
    STB_IORD,
    STB_IOWR
  } stb_e;

  typedef struct packed {
    stb_e stb;
    logic reg_lvl;
  } bus_sel_t;

  function automatic bus_sel_t cmd_decode(input logic [2:0] t);
    bus_sel_t s;
    s.stb     = STB_NONE;
    s.reg_lvl = 1'b1;
    unique case (1'b1)
      (t == CMD_ATTR_RD): begin s.stb = STB_OE;   s.reg_lvl = 1'b0; end
      (t == CMD_ATTR_WR): begin s.stb = STB_WE;   s.reg_lvl = 1'b0; end
      (t == CMD_MEM_RD):  begin s.stb = STB_OE;   s.reg_lvl = 1'b1; end
      (t == CMD_MEM_WR):  begin s.stb = STB_WE;   s.reg_lvl = 1'b1; end
      (t == CMD_IO_RD):   begin s.stb = STB_IORD; s.reg_lvl = 1'b0; end
      (t == CMD_IO_WR):   begin s.stb = STB_IOWR; s.reg_lvl = 1'b0; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic cmd_is_wr(input logic [2:0] t);
    return (t == CMD_ATTR_WR) || (t == CMD_MEM_WR) || (t == CMD_IO_WR);
  endfunction

  function automatic logic cmd_is_rd(input logic [2:0] t);
    return (t == CMD_ATTR_RD) || (t == CMD_MEM_RD) || (t == CMD_IO_RD);
  endfunction

endpackage

// File: rtl/pcmcia_host_master_sync2.sv
// Two-flop synchroniser, resets to 1 (card status deasserted).
// Ports: clk, rst_n, d (async in), q (synchronised out).
module pcmcia_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pcmcia_host_master.sv
// PCMCIA/CF 8-bit host initiator: one command in, one timed card cycle out.
// Ports: cmd_* request, rsp_* completion, A/D/CE/REG/strobes to card, WAIT/INPACK in.
module pcmcia_host_master
  import pcmcia_host_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 8,
  parameter int T_HOLD   = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic        clk_26,
  input  logic        RESETB,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        CE1,
  output logic        CE2,
  output logic        REG,
  output logic        OE,
  output logic        WE,
  output logic        IORD,
  output logic        IOWR,
  input  logic        WAIT,
  input  logic        INPACK
);

  localparam logic [7:0] SET_LAST  = 8'(T_SETUP - 1);
  localparam logic [7:0] STB_LAST  = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LAST = 8'(T_HOLD - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e   state;
  logic [7:0] cnt;
  stb_e     stb_q;
  logic     rsvd_q;
  logic     rd_q;
  logic     io_rd_q;
  logic     to_q;
  logic     inpack_seen;
  logic [7:0] rdata_q;
  logic     wait_s;
  logic     inpack_s;
  logic     fin;
  bus_sel_t dsel;

  pcmcia_sync2 u_wait_sync (
    .clk   (clk_26),
    .rst_n (RESETB),
    .d     (WAIT),
    .q     (wait_s)
  );

  pcmcia_sync2 u_inpack_sync (
    .clk   (clk_26),
    .rst_n (RESETB),
    .d     (INPACK),
    .q     (inpack_s)
  );

  assign dsel = cmd_decode(cmd_type);
  assign CE2  = 1'b1;

  // Reserved commands leave SETUP at once; real ones after HOLD.
  assign fin = ((state == ST_SETUP) && rsvd_q) ||
               ((state == ST_HOLD) && (cnt == HOLD_LAST));

  always_ff @(posedge clk_26 or negedge RESETB) begin
    if (!RESETB) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      stb_q       <= STB_NONE;
      rsvd_q      <= 1'b0;
      rd_q        <= 1'b0;
      io_rd_q     <= 1'b0;
      to_q        <= 1'b0;
      inpack_seen <= 1'b0;
      rdata_q     <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_status  <= '0;
      A           <= '0;
      D_out       <= '0;
      D_oe        <= 1'b0;
      CE1         <= 1'b1;
      REG         <= 1'b1;
      OE          <= 1'b1;
      WE          <= 1'b1;
      IORD        <= 1'b1;
      IOWR        <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            state       <= ST_SETUP;
            stb_q       <= dsel.stb;
            rsvd_q      <= (dsel.stb == STB_NONE);
            to_q        <= (dsel.stb == STB_NONE);
            rd_q        <= cmd_is_rd(cmd_type);
            io_rd_q     <= (cmd_type == CMD_IO_RD);
            inpack_seen <= 1'b0;
            if (dsel.stb != STB_NONE) begin
              A   <= cmd_addr;
              CE1 <= 1'b0;
              REG <= dsel.reg_lvl;
              if (cmd_is_wr(cmd_type)) begin
                D_oe  <= 1'b1;
                D_out <= cmd_wdata;
              end
            end
          end
        end
        ST_SETUP: begin
          if (!rsvd_q) begin
            if (cnt == SET_LAST) begin
              cnt   <= '0;
              state <= ST_STROBE;
              OE    <= (stb_q != STB_OE);
              WE    <= (stb_q != STB_WE);
              IORD  <= (stb_q != STB_IORD);
              IOWR  <= (stb_q != STB_IOWR);
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_STROBE, ST_STRETCH: begin
          if (io_rd_q && !inpack_s) inpack_seen <= 1'b1;
          if (state == ST_STROBE && cnt != STB_LAST) begin
            cnt <= cnt + 8'd1;
          end else if (state == ST_STROBE && !wait_s) begin
            cnt   <= '0;
            state <= ST_STRETCH;
          end else if (wait_s || cnt == WAIT_LAST) begin
            // Data sampled with the strobe still low on this edge.
            if (!wait_s) to_q <= 1'b1;
            cnt     <= '0;
            state   <= ST_HOLD;
            rdata_q <= D_in;
            OE      <= 1'b1;
            WE      <= 1'b1;
            IORD    <= 1'b1;
            IOWR    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          cnt <= cnt + 8'd1;
        end
        ST_RESP: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (fin) begin
        state      <= ST_RESP;
        cnt        <= '0;
        rsp_valid  <= 1'b1;
        rsp_rdata  <= rd_q ? rdata_q : 8'h00;
        rsp_status[STAT_TIMEOUT]   <= to_q;
        rsp_status[STAT_NO_INPACK] <= io_rd_q && !inpack_seen;
        CE1        <= 1'b1;
        REG        <= 1'b1;
        D_oe       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcmcia_host_master.sv
// Randomised bench for pcmcia_host_master against a cycle-count card model.
// Directed test-plan cases first, then random commands.
module tb_pcmcia_host_master;

  localparam int TS = 2;
  localparam int TB = 8;
  localparam int TH = 2;
  localparam int WM = 255;

  logic        clk_26 = 1'b0;
  logic        RESETB;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_status;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in;
  logic        CE1, CE2, REG, OE, WE, IORD, IOWR;
  logic        WAIT, INPACK;

  int checks = 0;
  int errors = 0;

  always #5 clk_26 = ~clk_26;

  pcmcia_host_master #(
    .T_SETUP(TS), .T_STROBE(TB), .T_HOLD(TH), .WAIT_MAX(WM)
  ) dut (
    .clk_26(clk_26), .RESETB(RESETB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .CE1(CE1), .CE2(CE2), .REG(REG), .OE(OE), .WE(WE),
    .IORD(IORD), .IOWR(IOWR), .WAIT(WAIT), .INPACK(INPACK)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // l: strobe-low cycles the card lets pass before releasing WAIT
  // (0 = WAIT never asserted, huge = never released).
  task automatic run_cmd(input logic [2:0] t, input logic [15:0] a,
                         input logic [7:0] wd, input int l,
                         input bit ip_lo, input logic [7:0] cd);
    bit rsv, rd, wr, regl, e_to, got;
    int stb, e_low, e_lat, m;
    int n, low_cnt, first_low, wrong, multi, ce_cnt, abad, rbad;
    int doe_cnt, dbad, lat;
    logic [3:0] sv;
    logic [7:0] o_rd;
    logic [1:0] o_st, e_st;
    rsv  = (t > 3'd5);
    rd   = (t == 3'd0) || (t == 3'd2) || (t == 3'd4);
    wr   = (t == 3'd1) || (t == 3'd3) || (t == 3'd5);
    regl = (t == 3'd2) || (t == 3'd3);
    stb  = rsv ? -1 : (t == 3'd4) ? 2 : (t == 3'd5) ? 3 : rd ? 0 : 1;
    e_to = rsv;
    e_low = TB;
    if (l > 0) begin
      m = (l + 2 > TB) ? l + 2 : TB;
      if (m > TB + WM) begin
        m = TB + WM;
        e_to = 1'b1;
      end
      e_low = m;
    end
    if (rsv) e_low = 0;
    e_lat = rsv ? 2 : 1 + TS + e_low + TH;
    e_st  = {(t == 3'd4) && !ip_lo, e_to};
    n = 0; low_cnt = 0; first_low = 0; wrong = 0; multi = 0;
    ce_cnt = 0; abad = 0; rbad = 0; doe_cnt = 0; dbad = 0;
    lat = 0; got = 0; o_rd = '0; o_st = '0;
    @(negedge clk_26);
    cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_wdata = wd;
    WAIT = (l == 0); INPACK = !ip_lo; D_in = cd;
    chk("ready_idle", cmd_ready, 1);
    @(posedge clk_26);
    #1 cmd_valid = 1'b0;
    while (!got && n < 600) begin
      @(negedge clk_26);
      n++;
      if (n == 1) chk("ready_busy", cmd_ready, 0);
      sv = {IOWR, IORD, WE, OE};
      if ($countones(sv) < 3) multi++;
      for (int i = 0; i < 4; i++) begin
        if (!sv[i]) begin
          if (i == stb) begin
            low_cnt++;
            if (first_low == 0) first_low = n;
          end else begin
            wrong++;
          end
        end
      end
      if (!CE1) begin
        ce_cnt++;
        if (A !== a) abad++;
        if (REG !== regl) rbad++;
      end
      if (D_oe) begin
        doe_cnt++;
        if (D_out !== wd) dbad++;
      end
      if (l > 0 && low_cnt == l) WAIT = 1'b1;
      if (rsp_valid) begin
        got = 1'b1; lat = n; o_rd = rsp_rdata; o_st = rsp_status;
      end
    end
    chk("rsp_seen", got, 1);
    chk("latency", lat, e_lat);
    chk("rdata", o_rd, rd ? cd : 8'h00);
    chk("status", o_st, e_st);
    chk("strobe_low", low_cnt, e_low);
    chk("strobe_start", first_low, rsv ? 0 : TS + 1);
    chk("wrong_strobe", wrong, 0);
    chk("multi_strobe", multi, 0);
    chk("ce1_low", ce_cnt, rsv ? 0 : TS + e_low + TH);
    chk("addr_bad", abad, 0);
    chk("reg_bad", rbad, 0);
    chk("doe_cycles", doe_cnt, wr ? TS + e_low + TH : 0);
    chk("dout_bad", dbad, 0);
    @(negedge clk_26);
    chk("rsp_pulse", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
    chk("rdata_held", rsp_rdata, o_rd);
    WAIT = 1'b1; INPACK = 1'b1;
  endtask

  initial begin
    int k, n, r, l;
    RESETB = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0;
    cmd_wdata = '0; D_in = '0; WAIT = 1'b1; INPACK = 1'b1;
    repeat (3) @(negedge clk_26);
    chk("rst_ctl", {CE1, CE2, REG, OE, WE, IORD, IOWR}, 7'h7f);
    chk("rst_bus", {A, D_out, D_oe}, 25'h0);
    chk("rst_rsp", {cmd_ready, rsp_valid, rsp_rdata, rsp_status}, 12'h0);
    RESETB = 1'b1;
    @(negedge clk_26);
    chk("rst_ready", cmd_ready, 1);

    run_cmd(3'd0, 16'h0000, 8'h00, 0, 1'b0, 8'h01);
    run_cmd(3'd3, 16'h0123, 8'h5A, 0, 1'b0, 8'hEE);
    run_cmd(3'd4, 16'h0010, 8'h00, 28, 1'b1, 8'hC3);
    run_cmd(3'd4, 16'h0020, 8'h00, 100000, 1'b0, 8'h77);
    run_cmd(3'd7, 16'hBEEF, 8'h12, 0, 1'b0, 8'h99);
    run_cmd(3'd6, 16'h0001, 8'h34, 5, 1'b1, 8'h42);

    // Reset during the stretch of an ATTR_WR.
    @(negedge clk_26);
    cmd_valid = 1'b1; cmd_type = 3'd1; cmd_addr = 16'h0300;
    cmd_wdata = 8'hA5; WAIT = 1'b0;
    @(posedge clk_26);
    #1 cmd_valid = 1'b0;
    k = 0; n = 0;
    while (k < 20 && n < 100) begin
      @(negedge clk_26);
      n++;
      if (!WE) k++;
    end
    chk("mid_stretch", k, 20);
    RESETB = 1'b0;
    #1;
    chk("mid_rst_ctl", {CE1, REG, OE, WE, IORD, IOWR}, 6'h3f);
    chk("mid_rst_rsp", {rsp_valid, cmd_ready, D_oe}, 3'b000);
    @(negedge clk_26);
    RESETB = 1'b1; WAIT = 1'b1;
    @(negedge clk_26);
    chk("mid_rel_ready", cmd_ready, 1);
    chk("mid_no_rsp", {rsp_valid, rsp_status}, 3'b000);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      l = (r < 3) ? 0 : (r < 9) ? $urandom_range(1, 40) : 300;
      run_cmd(3'($urandom_range(0, 7)), 16'($urandom),
              8'($urandom), l, 1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcmcia_host_master.md
# pcmcia_host_master

Host-side initiator for the 8-bit PCMCIA/CompactFlash card bus. It turns single-beat commands from an on-chip requester into correctly timed attribute-memory, common-memory and I/O cycles toward a card. It honours WAIT stretching and INPACK, and returns read data and a status word. It sits between the host system logic and the card connector, and it is also the bench driver for our card-side attribute ROM/SPI bridge.

## Interface
Parameters:
- T_SETUP, 2: address/CE/REG setup before strobe, in clk_26 cycles (≥1)
- T_STROBE, 8: minimum strobe-low width, cycles (≥2)
- T_HOLD, 2: address/data hold after strobe release, cycles (≥1)
- WAIT_MAX, 255: maximum stretch cycles before timeout (≤255)

Ports:
- clk_26  in  1  system clock, 26 MHz
- RESETB  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_type  in  3  0 ATTR_RD, 1 ATTR_WR, 2 MEM_RD, 3 MEM_WR, 4 IO_RD, 5 IO_WR; 6–7 reserved
- cmd_addr  in  16  card address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data; 0 for writes
- rsp_status  out  2  bit0 timeout, bit1 no-INPACK (IO_RD only)
- A  out  16  card address
- D_out  out  8  host write data
- D_oe  out  1  host drives D
- D_in  in  8  card data
- CE1, CE2, REG, OE, WE, IORD, IOWR  out  1 each  card controls, active-low
- WAIT, INPACK  in  1 each  card status, active-low, asynchronous

## Operation
- FSM states: IDLE, SETUP, STROBE, STRETCH, HOLD, RESP.
- IDLE: cmd_ready=1. On handshake, register type/addr/wdata and go to SETUP. A reserved type is accepted and completes as RESP with status=01 and no bus activity.
- SETUP (T_SETUP cycles): A=addr, CE1=0, CE2=1 (8-bit mode), REG=0 for ATTR_* and IO_*, REG=1 for MEM_*. For writes, D_oe=1 and D_out=wdata.
- STROBE (T_STROBE cycles): one strobe is low. OE for ATTR_RD/MEM_RD, WE for ATTR_WR/MEM_WR, IORD for IO_RD, IOWR for IO_WR.
  - On the last STROBE cycle, if synchronised WAIT=1, capture D_in (reads) and go to HOLD. Otherwise go to STRETCH.
- STRETCH: the strobe stays low and the counter increments each cycle.
  - When synchronised WAIT=1, capture D_in and go to HOLD.
  - If the counter reaches WAIT_MAX, set timeout, capture D_in anyway, and go to HOLD.
- INPACK: synchronised; a sticky flag sets if INPACK=0 on any STROBE/STRETCH cycle of an IO_RD. At completion, no-INPACK = ~flag.
- HOLD (T_HOLD cycles): strobe high; A, CE1, REG, D_out and D_oe unchanged.
- RESP (1 cycle): rsp_valid=1. CE1 and REG return to 1, D_oe=0. Next state is IDLE.
- rsp_rdata/rsp_status are held until the next RESP.
- Only one strobe is ever low at a time. Strobes are registered outputs, glitch-free.

## Timing
- WAIT and INPACK each go through a 2-flop synchroniser. A card de-asserting WAIT is seen 2 cycles later, and stretch adds that latency.
- Unstretched cycle, handshake to rsp_valid: 1 + T_SETUP + T_STROBE + T_HOLD cycles. This is 13 with the defaults.
- cmd_ready falls the cycle after the handshake and rises in the cycle after RESP. Back-to-back command throughput is one per 14 cycles.
- D_in is captured on the clock edge that ends the final strobe-low cycle, with the strobe still low.
- Reset values (asynchronous):
  - CE1=CE2=REG=OE=WE=IORD=IOWR=1
  - A=0, D_out=0, D_oe=0
  - cmd_ready=0 during reset, 1 on the first clock after RESETB rises
  - rsp_valid=0, rsp_rdata=0, rsp_status=0
- Reset mid-cycle: all strobes are released immediately, no response is issued, and the command is dropped.
- cmd_valid while busy is ignored; cmd_valid held through RESP is taken in IDLE.

## Structure
- Package pcmcia_host_pkg holds:
  - cmd_type encodings
  - FSM state enum
  - status bit indices
  - a helper function mapping cmd_type to strobe select and REG level
- Sub-module pcmcia_sync2: 2-flop synchroniser with reset value 1 (deasserted), instanced for WAIT and INPACK.
- The timing counter is 8 bits, shared across SETUP/STROBE/STRETCH/HOLD and cleared on every state change.

## Test plan
- ATTR_RD at 0x0000, card model returns 0x01 with WAIT=1 → OE low exactly 8 cycles, REG=0, rsp_rdata=0x01, status=00, rsp_valid 13 cycles after handshake.
- MEM_WR 0x5A to 0x0123 → REG=1, WE low 8 cycles, D_oe=1 from SETUP through HOLD, D_out=0x5A, status=00.
- IO_RD at 0x0010, card holds WAIT=0 for 20 cycles and drives INPACK=0, data 0xC3 → IORD low 30 cycles (8 + 20 + 2 sync), rsp_rdata=0xC3, status=00.
- IO_RD with WAIT stuck at 0 and INPACK=1 → strobe released after 8 + 255 cycles, status=11.
- RESETB pulled low during STRETCH of an ATTR_WR → all strobes and CE1 high within the reset assertion, no rsp_valid, cmd_ready=1 one cycle after release.
- Reserved cmd_type 7 → no strobe or CE1 activity, rsp_valid after 2 cycles with status=01.
